bin_monitor: RTL and testbench
==============================

# bin_monitor

Parametrised multi-bin sensor monitor for the board-level status display. It tracks NUM_BINS sensor/value channels, selects one by debounced push-button or automatic scan, and drives the 8-bit status LED bar and two active-low 7-segment digits showing the selected bin's value in decimal. An over-threshold alarm blinks the LED bar. Sits between the sensor-reading front end and the board pins, replacing the fixed three-bin selector.

## Interface
- NUM_BINS, 3, number of bins/channels (2..8)
- SENSOR_W, 8, sensor reading width per bin (must be 8, mapped to LED bar)
- VALUE_W, 4, value width per bin (1..7; values above 99 display as 99)
- DEBOUNCE_CYCLES, 16, cycles a synchronised button level must be stable to be accepted
- SCAN_TICKS, 50_000_000, cycles per bin in scan mode; also the blink half-period
- FULL_THRESH, 12, value at or above which the selected bin is in alarm

- Clk  in  1  single system clock
- Rst_n  in  1  synchronous, active-low reset
- CHOICE_button  in  NUM_BINS  raw asynchronous buttons, bit i selects bin i
- SCAN_en  in  1  1 = auto-scan mode, 0 = manual select (asynchronous, synchronised internally)
- SENSOR_bus  in  NUM_BINS*SENSOR_W  bin i at [i*SENSOR_W +: SENSOR_W]
- VALUE_bus  in  NUM_BINS*VALUE_W  bin i at [i*VALUE_W +: VALUE_W]
- sel_bin  out  $clog2(NUM_BINS)  currently displayed bin
- alarm  out  1  selected bin value >= FULL_THRESH
- STATUS_led  out  8  LED bar
- STATUS_7seg_ones  out  8  ones digit, active-low {dp,g,f,e,d,c,b,a}
- STATUS_7seg_tens  out  8  tens digit, same encoding

## Operation
- Reset (Rst_n low at a Clk edge): sel_bin=0, alarm=0, STATUS_led=8'h00, both 7seg=8'hFF (blank), state MANUAL, all counters 0, debounced levels 0, blink phase 0.
- Buttons and SCAN_en: 2-flop synchroniser each; each button debounced by a counter that clears on any change of synchronised level and accepts the level after DEBOUNCE_CYCLES equal samples.
- Press = rising edge of debounced level. Simultaneous presses: lowest index wins, others ignored.
- FSM states: MANUAL, SCAN.
  - MANUAL: a press on bin i sets sel_bin=i next cycle. SCAN_en sync high -> SCAN, scan counter cleared.
  - SCAN: scan counter counts 0..SCAN_TICKS-1; on terminal count sel_bin increments, wrapping NUM_BINS-1 -> 0. A press on bin i sets sel_bin=i and restarts the scan counter (press overrides same-cycle wrap). SCAN_en sync low -> MANUAL, sel_bin held.
- Display path (registered, every cycle, from current sel_bin):
  - v = VALUE of selected bin, clamped to 99; tens = v/10, ones = v%10; tens digit blank (8'hFF) when tens==0, ones always shown (0 shows "0").
  - alarm = (unclamped v >= FULL_THRESH).
  - STATUS_led = SENSOR of selected bin when alarm=0; when alarm=1, 8'hFF in blink phase 1, 8'h00 in blink phase 0.
  - Blink phase toggles every SCAN_TICKS cycles from a free-running counter independent of the FSM.
- dp segment always off (bit 7 = 1).

## Timing
- All outputs registered; no combinational input-to-output path.
- Bus change -> STATUS_led/7seg/alarm updated at the first Clk edge after (1-cycle latency).
- sel_bin change -> display reflects new bin one cycle later.
- Button: raw edge -> sel_bin update after 2 (sync) + DEBOUNCE_CYCLES + 1 (edge/select) cycles; bounce shorter than DEBOUNCE_CYCLES produces no press.
- Scan: sel_bin advances exactly every SCAN_TICKS cycles while in SCAN.
- Reset mid-debounce or mid-scan discards all progress; first press after reset needs full debounce.

## Structure
- Package bin_monitor_pkg: state enum {MANUAL, SCAN}, 7-segment digit constants 0-9, SEG_BLANK=8'hFF.
- One sub-module: btn_debounce (synchroniser + stability counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated NUM_BINS+1 times (SCAN_en uses the level output only).
- Binary-to-two-digit conversion inline (VALUE_W <= 7, compare/subtract by 10).

## Test plan
Bench params: NUM_BINS=3, DEBOUNCE_CYCLES=4, SCAN_TICKS=8, FULL_THRESH=12.
- Reset, then VALUE_bus bin0=7, SENSOR bin0=8'hA5 -> sel_bin=0, LED=8'hA5, ones=seg(7), tens=8'hFF, alarm=0.
- Press button 2 held 10 cycles with bin2 value 10 -> sel_bin=2 exactly 7 cycles after raw edge; ones=seg(0), tens=seg(1).
- 3-cycle bounce pulse on button 1 -> sel_bin unchanged; buttons 0 and 2 rise same cycle -> sel_bin=0.
- SCAN_en=1 held -> sel_bin sequence 0,1,2,0 at 8-cycle intervals; press button 1 mid-interval -> sel_bin=1, next advance 8 cycles later.
- Selected bin value 15 -> alarm=1, LED alternates 8'hFF/8'h00 every 8 cycles; ones=seg(5), tens=seg(1); value drops to 11 -> alarm=0, LED shows sensor next cycle.
- Rst_n low for one cycle during SCAN with sel_bin=2 -> sel_bin=0, state MANUAL, 7seg blank, LED 8'h00.

Source files
------------

// File: rtl/bin_monitor_pkg.sv
// Shared types, state codes and 7-segment helpers for the bin monitor.
package bin_monitor_pkg;

  typedef enum logic [0:0] {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_e;

  // Plain vector state codes keep the FSM register a simple logic vector.
  localparam logic [0:0] ST_MANUAL = MANUAL;
  localparam logic [0:0] ST_SCAN   = SCAN;

  // Active-low segments {dp,g,f,e,d,c,b,a}; dp always off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Clamp to 99 and split into {tens, ones} by repeated subtraction of 10.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] rem;
    logic [3:0] tens;
    logic       ge10;
    rem  = (v > 7'd99) ? 7'd99 : v;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      ge10 = (rem >= 7'd10);
      tens = tens + (ge10 ? 4'd1 : 4'd0);
      rem  = ge10 ? (rem - 7'd10) : rem;
    end
    return {tens, 4'(rem)};
  endfunction

endpackage

// File: rtl/bin_monitor_if.sv
// Board-side signal bundle of the bin monitor: buttons, buses and display pins.
interface bin_monitor_if #(
  parameter int NUM_BINS = 3,
  parameter int SENSOR_W = 8,
  parameter int VALUE_W  = 4
);
  localparam int SEL_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

  logic [NUM_BINS-1:0]          CHOICE_button;
  logic                         SCAN_en;
  logic [NUM_BINS*SENSOR_W-1:0] SENSOR_bus;
  logic [NUM_BINS*VALUE_W-1:0]  VALUE_bus;
  logic [SEL_W-1:0]             sel_bin;
  logic                         alarm;
  logic [7:0]                   STATUS_led;
  logic [7:0]                   STATUS_7seg_ones;
  logic [7:0]                   STATUS_7seg_tens;

  modport master (
    output CHOICE_button, SCAN_en, SENSOR_bus, VALUE_bus,
    input  sel_bin, alarm, STATUS_led, STATUS_7seg_ones, STATUS_7seg_tens
  );

  modport slave (
    input  CHOICE_button, SCAN_en, SENSOR_bus, VALUE_bus,
    output sel_bin, alarm, STATUS_led, STATUS_7seg_ones, STATUS_7seg_tens
  );
endinterface

// File: rtl/bin_monitor_btn_debounce.sv
// Two-flop synchroniser, stability-counter debouncer and rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level once it has differed from the
  // current one for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= {CW{1'b0}};
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= {CW{1'b0}};
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= {CW{1'b0}};
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = level & ~level_q;
endmodule

// File: rtl/bin_monitor.sv
// Multi-bin sensor monitor: button/scan bin selection, LED bar and 2-digit display.
module bin_monitor
  import bin_monitor_pkg::*;
#(
  parameter int NUM_BINS        = 3,
  parameter int SENSOR_W        = 8,
  parameter int VALUE_W         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_TICKS      = 50_000_000,
  parameter int FULL_THRESH     = 12
) (
  input  logic          Clk,
  input  logic          Rst_n,
  bin_monitor_if.slave  bus
);
  localparam int SEL_W  = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int SCAN_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_BINS - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_TICKS - 1);

  logic [NUM_BINS-1:0] btn_level_unused;
  logic [NUM_BINS-1:0] btn_rise;
  logic                scan_level;
  logic                scan_rise_unused;

  for (genvar i = 0; i < NUM_BINS; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk(Clk), .rst_n(Rst_n), .raw(bus.CHOICE_button[i]),
      .level(btn_level_unused[i]), .rise(btn_rise[i])
    );
  end

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_scan (
    .clk(Clk), .rst_n(Rst_n), .raw(bus.SCAN_en),
    .level(scan_level), .rise(scan_rise_unused)
  );

  logic              press;
  logic [SEL_W-1:0]  press_idx;
  logic [0:0]        state;
  logic [SEL_W-1:0]  sel;
  logic [SCAN_W-1:0] scan_cnt;
  logic [SCAN_W-1:0] blink_cnt;
  logic              blink_phase;

  // Priority-encode simultaneous presses so the lowest bin index wins.
  always_comb begin
    press     = |btn_rise;
    press_idx = {SEL_W{1'b0}};
    for (int i = NUM_BINS - 1; i >= 0; i--) begin
      press_idx = btn_rise[i] ? SEL_W'(i) : press_idx;
    end
  end

  // Selection FSM: manual pick, or timed scan that a press can override.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= ST_MANUAL;
      sel      <= {SEL_W{1'b0}};
      scan_cnt <= {SCAN_W{1'b0}};
    end else begin
      case (state)
        ST_MANUAL: begin
          scan_cnt <= {SCAN_W{1'b0}};
          if (press) sel <= press_idx;
          if (scan_level) state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (!scan_level) begin
            state    <= ST_MANUAL;
            scan_cnt <= {SCAN_W{1'b0}};
            if (press) sel <= press_idx;
          end else if (press) begin
            sel      <= press_idx;
            scan_cnt <= {SCAN_W{1'b0}};
          end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= {SCAN_W{1'b0}};
            sel      <= (sel == SEL_LAST) ? {SEL_W{1'b0}} : sel + SEL_W'(1);
          end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
          end
        end
        default: begin
          state    <= ST_MANUAL;
          scan_cnt <= {SCAN_W{1'b0}};
        end
      endcase
    end
  end

  // Free-running blink timebase, independent of the selection FSM.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      blink_cnt   <= {SCAN_W{1'b0}};
      blink_phase <= 1'b0;
    end else if (blink_cnt == SCAN_LAST) begin
      blink_cnt   <= {SCAN_W{1'b0}};
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + SCAN_W'(1);
    end
  end

  logic [VALUE_W-1:0]  value_sel;
  logic [SENSOR_W-1:0] sensor_sel;
  logic [7:0]          bcd;
  logic                alarm_next;

  // Pick the selected bin and derive its alarm flag and decimal digits.
  always_comb begin
    value_sel  = bus.VALUE_bus[int'(sel) * VALUE_W +: VALUE_W];
    sensor_sel = bus.SENSOR_bus[int'(sel) * SENSOR_W +: SENSOR_W];
    alarm_next = (int'(value_sel) >= FULL_THRESH);
    bcd        = to_bcd(7'(value_sel));
  end

  logic       alarm_r;
  logic [7:0] led_r;
  logic [7:0] ones_r;
  logic [7:0] tens_r;

  // Register every display output; tens digit blanks for single-digit values.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      alarm_r <= 1'b0;
      led_r   <= 8'h00;
      ones_r  <= SEG_BLANK;
      tens_r  <= SEG_BLANK;
    end else begin
      alarm_r <= alarm_next;
      led_r   <= alarm_next ? {8{blink_phase}} : 8'(sensor_sel);
      ones_r  <= seg_digit(bcd[3:0]);
      tens_r  <= (bcd[7:4] == 4'd0) ? SEG_BLANK : seg_digit(bcd[7:4]);
    end
  end

  assign bus.sel_bin          = sel;
  assign bus.alarm            = alarm_r;
  assign bus.STATUS_led       = led_r;
  assign bus.STATUS_7seg_ones = ones_r;
  assign bus.STATUS_7seg_tens = tens_r;
endmodule

// File: tb/tb_bin_monitor.sv
// Self-checking bench for bin_monitor: per-cycle reference model plus directed checks.
module tb_bin_monitor;
  localparam int NB = 3, SW = 8, VW = 4, DB = 4, ST = 8, TH = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bin_monitor_if #(.NUM_BINS(NB), .SENSOR_W(SW), .VALUE_W(VW)) bus ();

  bin_monitor #(
    .NUM_BINS(NB), .SENSOR_W(SW), .VALUE_W(VW),
    .DEBOUNCE_CYCLES(DB), .SCAN_TICKS(ST), .FULL_THRESH(TH)
  ) dut (
    .Clk(clk), .Rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Debounced level = value of the last DB synchronised samples when they all
  // agree; synchronised sample at an edge = raw input seen two edges earlier.
  logic [NB-1:0] hist_btn [0:DB+1];
  logic          hist_scan[0:DB+1];
  logic [NB-1:0] m_lvl, m_lvl_prev;
  logic          m_scan_lvl;
  bit            m_scan_mode;
  int            m_sel, m_cyc, m_anchor;
  int            e_sel;
  logic          e_alarm;
  logic [7:0]    e_led, e_ones, e_tens;
  bit            model_ok = 0;

  initial begin
    int v, c, pidx;
    logic [NB-1:0] press, nl;
    logic ns;
    bit same;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int j = 0; j <= DB + 1; j++) begin hist_btn[j] = '0; hist_scan[j] = 1'b0; end
        m_lvl = '0; m_lvl_prev = '0; m_scan_lvl = 1'b0; m_scan_mode = 0;
        m_sel = 0; m_cyc = 0; m_anchor = 0;
        e_sel = 0; e_alarm = 1'b0; e_led = 8'h00; e_ones = 8'hFF; e_tens = 8'hFF;
        model_ok = 1;
      end else begin
        // display of the bin selected before this edge
        v = int'(bus.VALUE_bus[m_sel*VW +: VW]);
        e_alarm = (v >= TH);
        c = (v > 99) ? 99 : v;
        e_tens = (c / 10 == 0) ? 8'hFF : seg(c / 10);
        e_ones = seg(c % 10);
        if (e_alarm) e_led = (((m_cyc / ST) % 2) == 1) ? 8'hFF : 8'h00;
        else         e_led = bus.SENSOR_bus[m_sel*SW +: SW];
        // selection
        press = m_lvl & ~m_lvl_prev;
        pidx = 0;
        for (int i = NB - 1; i >= 0; i--) if (press[i]) pidx = i;
        if (m_scan_mode) begin
          if (!m_scan_lvl) begin
            m_scan_mode = 0;
            if (press != 0) m_sel = pidx;
          end else if (press != 0) begin
            m_sel = pidx; m_anchor = m_cyc;
          end else if (m_cyc - m_anchor == ST) begin
            m_sel = (m_sel + 1) % NB; m_anchor = m_cyc;
          end
        end else begin
          if (press != 0) m_sel = pidx;
          if (m_scan_lvl) begin m_scan_mode = 1; m_anchor = m_cyc; end
        end
        e_sel = m_sel;
        // debounce windows
        for (int j = DB + 1; j >= 1; j--) begin hist_btn[j] = hist_btn[j-1]; hist_scan[j] = hist_scan[j-1]; end
        hist_btn[0] = bus.CHOICE_button;
        hist_scan[0] = bus.SCAN_en;
        nl = m_lvl;
        for (int b = 0; b < NB; b++) begin
          same = 1;
          for (int j = 3; j <= DB + 1; j++) if (hist_btn[j][b] != hist_btn[2][b]) same = 0;
          if (same) nl[b] = hist_btn[2][b];
        end
        ns = m_scan_lvl;
        same = 1;
        for (int j = 3; j <= DB + 1; j++) if (hist_scan[j] != hist_scan[2]) same = 0;
        if (same) ns = hist_scan[2];
        m_lvl_prev = m_lvl; m_lvl = nl; m_scan_lvl = ns;
        m_cyc++;
      end
    end
  end

  // Compare every cycle against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("m_sel",   32'(bus.sel_bin),          32'(e_sel));
      check("m_alarm", 32'(bus.alarm),            32'(e_alarm));
      check("m_led",   32'(bus.STATUS_led),       32'(e_led));
      check("m_ones",  32'(bus.STATUS_7seg_ones), 32'(e_ones));
      check("m_tens",  32'(bus.STATUS_7seg_tens), 32'(e_tens));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sel(input string name, input int val, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(bus.sel_bin) == val) break;
    end
    check(name, 32'(bus.sel_bin), 32'(val));
  endtask

  initial begin
    int n_ff, n_00;
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ff, n_00;
    bus.CHOICE_button = 3'b000;
    bus.SCAN_en       = 1'b0;
    bus.VALUE_bus     = {4'd10, 4'd3, 4'd7};
    bus.SENSOR_bus    = {8'h5A, 8'h3C, 8'hA5};
    rst_n = 1'b0;
    tick(2);
    check("rst_sel", 32'(bus.sel_bin), 32'd0);
    check("rst_led", 32'(bus.STATUS_led), 32'h00);
    check("rst_ones", 32'(bus.STATUS_7seg_ones), 32'hFF);
    check("rst_tens", 32'(bus.STATUS_7seg_tens), 32'hFF);
    check("rst_alarm", 32'(bus.alarm), 32'd0);
    rst_n = 1'b1;
    tick(2);
    check("b0_led", 32'(bus.STATUS_led), 32'hA5);
    check("b0_ones", 32'(bus.STATUS_7seg_ones), 32'hF8);
    check("b0_tens", 32'(bus.STATUS_7seg_tens), 32'hFF);
    check("b0_alarm", 32'(bus.alarm), 32'd0);

    // press button 2: selection lands exactly 7 cycles after the raw edge
    bus.CHOICE_button = 3'b100;
    tick(6);
    check("press_early", 32'(bus.sel_bin), 32'd0);
    tick(1);
    check("press_latency", 32'(bus.sel_bin), 32'd2);
    tick(1);
    check("b2_ones", 32'(bus.STATUS_7seg_ones), 32'hC0);
    check("b2_tens", 32'(bus.STATUS_7seg_tens), 32'hF9);
    check("b2_led", 32'(bus.STATUS_led), 32'h5A);
    tick(2);
    bus.CHOICE_button = 3'b000;
    tick(10);

    // short bounce is ignored
    bus.CHOICE_button = 3'b010;
    tick(3);
    bus.CHOICE_button = 3'b000;
    tick(12);
    check("bounce", 32'(bus.sel_bin), 32'd2);

    // simultaneous presses: lowest index wins
    bus.CHOICE_button = 3'b101;
    tick(8);
    check("simul", 32'(bus.sel_bin), 32'd0);
    bus.CHOICE_button = 3'b000;
    tick(10);

    // scan mode 0 -> 1 -> 2 -> 0 every 8 cycles
    bus.SCAN_en = 1'b1;
    wait_sel("scan_first", 1, 30);
    tick(7);
    check("scan_hold1", 32'(bus.sel_bin), 32'd1);
    tick(1);
    check("scan_adv2", 32'(bus.sel_bin), 32'd2);
    tick(7);
    check("scan_hold2", 32'(bus.sel_bin), 32'd2);
    tick(1);
    check("scan_wrap0", 32'(bus.sel_bin), 32'd0);
    // press mid-interval restarts the scan period
    bus.CHOICE_button = 3'b010;
    tick(6);
    check("scan_pre_press", 32'(bus.sel_bin), 32'd0);
    tick(1);
    check("scan_press", 32'(bus.sel_bin), 32'd1);
    tick(6);
    bus.CHOICE_button = 3'b000;
    tick(1);
    check("scan_restart_hold", 32'(bus.sel_bin), 32'd1);
    tick(1);
    check("scan_restart_adv", 32'(bus.sel_bin), 32'd2);

    // alarm with blinking LED bar
    bus.SCAN_en = 1'b0;
    tick(10);
    bus.CHOICE_button = 3'b010;
    tick(8);
    bus.CHOICE_button = 3'b000;
    tick(8);
    check("alarm_sel", 32'(bus.sel_bin), 32'd1);
    bus.VALUE_bus = {4'd10, 4'd15, 4'd7};
    tick(1);
    check("alarm_on", 32'(bus.alarm), 32'd1);
    check("alarm_ones", 32'(bus.STATUS_7seg_ones), 32'h92);
    check("alarm_tens", 32'(bus.STATUS_7seg_tens), 32'hF9);
    n_ff = 0; n_00 = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.STATUS_led == 8'hFF) n_ff++;
      if (bus.STATUS_led == 8'h00) n_00++;
      tick(1);
    end
    check("blink_on_count", 32'(n_ff), 32'd8);
    check("blink_off_count", 32'(n_00), 32'd8);
    bus.VALUE_bus = {4'd10, 4'd11, 4'd7};
    tick(1);
    check("alarm_off", 32'(bus.alarm), 32'd0);
    check("alarm_off_led", 32'(bus.STATUS_led), 32'h3C);
    check("v11_ones", 32'(bus.STATUS_7seg_ones), 32'hF9);
    check("v11_tens", 32'(bus.STATUS_7seg_tens), 32'hF9);

    // reset in the middle of scanning
    bus.SCAN_en = 1'b1;
    wait_sel("scan_to2", 2, 40);
    rst_n = 1'b0;
    tick(1);
    check("rst2_sel", 32'(bus.sel_bin), 32'd0);
    check("rst2_led", 32'(bus.STATUS_led), 32'h00);
    check("rst2_ones", 32'(bus.STATUS_7seg_ones), 32'hFF);
    check("rst2_tens", 32'(bus.STATUS_7seg_tens), 32'hFF);
    check("rst2_alarm", 32'(bus.alarm), 32'd0);
    rst_n = 1'b1;
    tick(10);
    check("rst2_manual", 32'(bus.sel_bin), 32'd0);
    tick(5);
    check("rst2_rescan", 32'(bus.sel_bin), 32'd1);
    bus.SCAN_en = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
